// File: rtl/dma_mem_responder_if.sv
// Bus bundle for dma_mem_responder: peripheral register port, DMA master port,
// CPU arbitration hint and the RAM-side port.
interface dma_mem_responder_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] dma_dout;

  logic        cpu_mem_busy;
  logic        dma_owns_mem;

  logic        mem_en;
  logic [14:0] mem_addr;
  logic [1:0]  mem_wen;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  modport slave (
    input  per_addr, per_din, per_en, per_we,
    input  dma_addr, dma_din, dma_en, dma_we, dma_priority,
    input  cpu_mem_busy, mem_dout,
    output per_dout, dma_ready, dma_resp, dma_dout, dma_owns_mem,
    output mem_en, mem_addr, mem_wen, mem_din
  );

  modport master (
    output per_addr, per_din, per_en, per_we,
    output dma_addr, dma_din, dma_en, dma_we, dma_priority,
    output cpu_mem_busy, mem_dout,
    input  per_dout, dma_ready, dma_resp, dma_dout, dma_owns_mem,
    input  mem_en, mem_addr, mem_wen, mem_din
  );
endinterface

// File: rtl/dma_mem_responder.sv
// DMA memory-side responder: CPU/DMA arbitration, protected-window guard with
// violation capture, activity counters and a one-stage response pipeline.
//
// state    | meaning
// ST_IDLE  | no response pending, dma_dout=0, dma_resp=0
// ST_RD    | accepted read last cycle, dma_dout follows mem_dout
// ST_ERR   | rejected access last cycle, dma_resp=1, dma_dout=0
module dma_mem_responder #(
  parameter logic [14:0] BASE_ADDR = 15'h0080,
  parameter int          DEC_WD    = 4
) (
  input logic                 mclk,
  input logic                 puc_rst,
  dma_mem_responder_if.slave  bus
);

  localparam logic [DEC_WD-1:0] OFF_PROT_LO = DEC_WD'(4'h0);
  localparam logic [DEC_WD-1:0] OFF_PROT_HI = DEC_WD'(4'h2);
  localparam logic [DEC_WD-1:0] OFF_CTRL    = DEC_WD'(4'h4);
  localparam logic [DEC_WD-1:0] OFF_VIOL    = DEC_WD'(4'h6);
  localparam logic [DEC_WD-1:0] OFF_STALL   = DEC_WD'(4'h8);
  localparam logic [DEC_WD-1:0] OFF_GRANT   = DEC_WD'(4'hA);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_ERR} state_t;

  state_t      state_q, state_d;
  logic [15:0] prot_lo_q, prot_lo_d;
  logic [15:0] prot_hi_q, prot_hi_d;
  logic        gen_q, gen_d;
  logic        viol_q, viol_d;
  logic [15:0] viol_addr_q, viol_addr_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  logic              reg_sel, reg_wr, reg_rd;
  logic [DEC_WD-1:0] reg_off;
  logic [15:0]       dma_byte, lo_byte, hi_byte;
  logic              grant, hit, accept, reject;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign reg_sel = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off = {bus.per_addr[DEC_WD-2:0], 1'b0};
  assign reg_wr  = reg_sel & (|bus.per_we);
  assign reg_rd  = reg_sel & ~(|bus.per_we);

  // Window compare on byte addresses; bit0 of the bounds never matters.
  assign dma_byte = {bus.dma_addr, 1'b0};
  assign lo_byte  = {prot_lo_q[15:1], 1'b0};
  assign hi_byte  = {prot_hi_q[15:1], 1'b0};

  assign grant  = bus.dma_en & (~bus.cpu_mem_busy | bus.dma_priority) & ~puc_rst;
  assign hit    = gen_q & (dma_byte >= lo_byte) & (dma_byte <= hi_byte);
  assign accept = grant & ~hit;
  assign reject = grant & hit;

  always_comb begin
    bus.dma_ready    = grant;
    bus.dma_owns_mem = accept;
    bus.mem_en       = accept;
    bus.mem_addr     = accept ? bus.dma_addr : 15'd0;
    bus.mem_wen      = accept ? bus.dma_we   : 2'b00;
    bus.mem_din      = accept ? bus.dma_din  : 16'd0;
    bus.dma_resp     = (state_q == ST_ERR);
    bus.dma_dout     = (state_q == ST_RD) ? bus.mem_dout : 16'd0;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (reject) begin
      state_d = ST_ERR;
    end else if (accept && (bus.dma_we == 2'b00)) begin
      state_d = ST_RD;
    end
  end

  always_comb begin
    prot_lo_d   = prot_lo_q;
    prot_hi_d   = prot_hi_q;
    gen_d       = gen_q;
    viol_d      = viol_q;
    viol_addr_d = viol_addr_q;
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;

    if (bus.dma_en && !grant) stall_cnt_d = sat_inc(stall_cnt_q);
    if (accept)               grant_cnt_d = sat_inc(grant_cnt_q);

    if (reg_wr) begin
      case (reg_off)
        OFF_PROT_LO: prot_lo_d = bus.per_din;
        OFF_PROT_HI: prot_hi_d = bus.per_din;
        OFF_CTRL: begin
          gen_d = bus.per_din[0];
          if (bus.per_din[1]) viol_d = 1'b0;
        end
        OFF_STALL:   stall_cnt_d = 16'd0;
        OFF_GRANT:   grant_cnt_d = 16'd0;
        default: ;
      endcase
    end

    // A violation in the same cycle as a W1C must survive the clear.
    if (reject) begin
      viol_d      = 1'b1;
      viol_addr_d = dma_byte;
    end
  end

  always_comb begin
    bus.per_dout = 16'd0;
    if (reg_rd) begin
      case (reg_off)
        OFF_PROT_LO: bus.per_dout = prot_lo_q;
        OFF_PROT_HI: bus.per_dout = prot_hi_q;
        OFF_CTRL:    bus.per_dout = {14'd0, viol_q, gen_q};
        OFF_VIOL:    bus.per_dout = viol_addr_q;
        OFF_STALL:   bus.per_dout = stall_cnt_q;
        OFF_GRANT:   bus.per_dout = grant_cnt_q;
        default:     bus.per_dout = 16'd0;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q     <= ST_IDLE;
      prot_lo_q   <= 16'd0;
      prot_hi_q   <= 16'd0;
      gen_q       <= 1'b0;
      viol_q      <= 1'b0;
      viol_addr_q <= 16'd0;
      stall_cnt_q <= 16'd0;
      grant_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      prot_lo_q   <= prot_lo_d;
      prot_hi_q   <= prot_hi_d;
      gen_q       <= gen_d;
      viol_q      <= viol_d;
      viol_addr_q <= viol_addr_d;
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Memory-side responder for the openMSP430 DMA master interface (dma_addr/dma_en/dma_we/dma_priority/dma_ready/dma_resp/dma_dout). It sits between any DMA initiator, including the DMA attacker peripheral, and a single-port synchronous data RAM. It arbitrates against CPU memory traffic and blocks DMA access to a programmable protected window (enclave memory). It also exposes guard configuration, violation capture and activity counters on the peripheral bus.

## Interface
- BASE_ADDR, 15'h0080, peripheral register base (16-byte aligned)
- DEC_WD, 4, decoder width; registers at offsets 0x0 PROT_LO, 0x2 PROT_HI, 0x4 CTRL, 0x6 VIOL_ADDR, 0x8 STALL_CNT, 0xA GRANT_CNT
- mclk  in  1  main system clock, single clock domain
- puc_rst  in  1  reset, asynchronous, active-high
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  peripheral write enable; any bit set means full 16-bit write
- per_dout  out  16  register read data; 0 when not selected
- dma_addr  in  15  DMA word address [15:1]
- dma_din  in  16  DMA write data
- dma_en  in  1  DMA request, held by initiator until dma_ready
- dma_we  in  2  DMA byte write enables; 00 = read
- dma_priority  in  1  DMA wins over CPU when high
- dma_ready  out  1  request accepted this cycle
- dma_resp  out  1  error response, cycle after a rejected access
- dma_dout  out  16  read data, cycle after acceptance
- cpu_mem_busy  in  1  CPU is requesting RAM this cycle
- dma_owns_mem  out  1  RAM granted to DMA this cycle; frontend stalls CPU
- mem_en  out  1  RAM enable
- mem_addr  out  15  RAM word address
- mem_wen  out  2  RAM byte write enables
- mem_din  out  16  RAM write data
- mem_dout  in  16  RAM read data, valid one cycle after mem_en

## Operation
- Grant: grant = dma_en & (~cpu_mem_busy | dma_priority) & ~puc_rst. This is combinational in the request cycle.
- Hit: hit = CTRL.GEN & ({dma_addr,0} >= PROT_LO & {dma_addr,0} <= PROT_HI). Comparison is on 16-bit byte addresses, with bit0 of PROT_LO/PROT_HI ignored. Bounds are inclusive. LO > HI gives an empty window.
- Granted and not hit:
  - dma_ready=1, dma_owns_mem=1, mem_en=1.
  - mem_addr=dma_addr, mem_wen=dma_we, mem_din=dma_din.
  - GRANT_CNT++.
- Granted and hit:
  - dma_ready=1, mem_en=0, dma_owns_mem=0.
  - Next cycle: dma_resp=1 and dma_dout=0.
  - CTRL.VIOL set; VIOL_ADDR <= {dma_addr,0}. The last violation overwrites.
- Not granted while dma_en=1: dma_ready=0, nothing driven to RAM, STALL_CNT++.
- When the block is not granting, mem_* outputs are 0 and dma_owns_mem=0. The external mux drives RAM for the CPU.
- Response pipeline, one-stage register with states IDLE, RD (accepted read), ERR (rejected access):
  - Next state = ERR if grant&hit, RD if grant&~hit&dma_we==0, else IDLE.
  - RD: dma_dout=mem_dout. ERR: dma_resp=1. IDLE: dma_dout=0, dma_resp=0.
  - A new request may be granted in the same cycle the previous response is presented. Back-to-back throughput is 1 access/cycle.
- Registers:
  - PROT_LO and PROT_HI are R/W.
  - CTRL: bit0 GEN is R/W. bit1 VIOL is read / write-1-to-clear. Other bits read 0.
  - VIOL_ADDR is read-only.
  - STALL_CNT and GRANT_CNT are read-only; any write clears them to 0.
- Counters are 16-bit and saturate at 16'hFFFF.
- per_dout is combinational in the read cycle and is 0 when not selected or on a write.

## Timing
- Reset values: all registers 0, state IDLE, dma_dout=0, dma_resp=0, per_dout=0.
- While puc_rst is high, dma_ready, dma_owns_mem and mem_en are forced 0.
- Asserting reset mid-transfer discards any pending RD/ERR response; no dma_resp is issued after reset.
- Read latency: dma_ready in cycle N, dma_dout valid in cycle N+1 only.
- Write: completes in cycle N, with no response cycle.
- Simultaneous events:
  - VIOL set and W1C in the same cycle: set wins.
  - Counter increment and clear-write in the same cycle: clear wins, result is 0.
  - PROT_*/CTRL write in the same cycle as a DMA request: the hit check uses the old register values.
- cpu_mem_busy and dma_priority are sampled combinationally each cycle. A stalled request is re-evaluated every cycle with no added latency.

## Test plan
- Write RAM 0x0200 with 0xBEEF over DMA (dma_we=11), then read it back: dma_ready is 1 in each request cycle, dma_dout=0xBEEF the cycle after the read, GRANT_CNT=2.
- Hold cpu_mem_busy=1 for 3 cycles with dma_priority=0: dma_ready=0 for 3 cycles, then 1. STALL_CNT=3. Repeat with dma_priority=1: immediate grant, dma_owns_mem=1.
- Set PROT_LO=0x0A00, PROT_HI=0x0AFE, GEN=1, then read 0x0A00, 0x0AFE and 0x0B00. The first two give dma_ready=1 with mem_en=0, then dma_resp=1 and dma_dout=0. For 0x0B00, mem_en=1 and no resp. VIOL=1 and VIOL_ADDR=0x0AFE after the sequence.
- Write 0x0002 to CTRL in the same cycle as a protected hit: VIOL reads 1. A later lone W1C clears it.
- Force STALL_CNT to 0xFFFF with 65540 stall cycles: it saturates at 0xFFFF. Write STALL_CNT during a stall cycle: it reads 0.
- Pulse puc_rst in the cycle after a read grant: dma_dout=0, dma_resp=0, all registers 0, mem_en=0 while reset is high.
